// File: rtl/sensor_hub.sv
// sensor_hub: multi-channel sensor sampler with per-channel circular buffers,
// a single-beat register-bus slave and a maskable sticky threshold interrupt.
//
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   req_valid/req_ready - request handshake (req_write, req_addr, req_wdata)
//   rsp_valid/rsp_ready - response handshake (rsp_rdata, rsp_err)
//   sensor_ready        - per-channel sample valid from the sensors
//   sensor_out          - per-channel sample data, channel c at [c*DW +: DW]
//   sensor_en           - per-channel sample request
//   sensor_interrupt    - OR of (STATUS & MASK)
//   bus_state_o         - bus FSM state (0 = IDLE, 1 = RESP), for observation
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high. Once raised, valid holds its payload stable until that edge; ready may
// be raised or lowered freely and never waits on valid.
//
// Register map (word-aligned, addr[1:0] ignored):
//   0x000 CTRL  RW   channel enable
//   0x004 STATUS R/W1C sticky threshold flags
//   0x008 MASK  RW   interrupt mask
//   0x00C THRESH RW  CW bits, resets to DEPTH
//   0x010 FLUSH WO   write 1 to bit c empties buffer c, reads 0
//   0x100+4c COUNT[c] RO fill count
//   0x200+4c DATA[c]  RO popping read; 0 and no pop when empty
// Any other address responds with rsp_err=1, read data 0, no side effects.

module sensor_hub #(
    parameter int NCH   = 4,
    parameter int DEPTH = 64,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [11:0]       req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    input  logic [NCH-1:0]    sensor_ready,
    input  logic [NCH*DW-1:0] sensor_out,
    output logic [NCH-1:0]    sensor_en,
    output logic              sensor_interrupt,
    output logic              bus_state_o
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [9:0]    WA_CTRL   = 10'h000;
    localparam logic [9:0]    WA_STATUS = 10'h001;
    localparam logic [9:0]    WA_MASK   = 10'h002;
    localparam logic [9:0]    WA_THRESH = 10'h003;
    localparam logic [9:0]    WA_FLUSH  = 10'h004;
    localparam logic [9:0]    WA_COUNT  = 10'h040;
    localparam logic [9:0]    WA_DATA   = 10'h080;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NCH-1:0] ctrl_q, ctrl_d;
    logic [NCH-1:0] status_q, status_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [CW-1:0]  thresh_q, thresh_d;
    logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [DW-1:0]  mem_q   [NCH][DEPTH];
    logic [AW-1:0]  wptr_q  [NCH];
    logic [AW-1:0]  wptr_d  [NCH];
    logic [AW-1:0]  rptr_q  [NCH];
    logic [AW-1:0]  rptr_d  [NCH];
    logic [CW-1:0]  count_q [NCH];
    logic [CW-1:0]  count_d [NCH];

    logic [9:0]     word_addr;
    logic           accept;
    logic           wr_en;
    logic           rd_en;
    logic           hit;
    logic [DW-1:0]  rd_data;
    logic           ctrl_we, mask_we, thresh_we;
    logic [NCH-1:0] w1c, flush, pop, push, set_flag;

    logic           unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_wdata[DW-1:NCH]};

    assign word_addr = req_addr[11:2];
    assign accept    = (state_q == S_IDLE) && req_valid;
    assign wr_en     = accept && req_write;
    assign rd_en     = accept && !req_write;

    // ------------------------------------------------------------------
    // Sampling side
    // ------------------------------------------------------------------
    always_comb begin
        sensor_en = '0;
        for (int c = 0; c < NCH; c++) begin
            sensor_en[c] = ctrl_q[c] && (count_q[c] != FULL);
        end
    end

    assign push = sensor_en & sensor_ready;

    // ------------------------------------------------------------------
    // Address decode and register read mux
    // ------------------------------------------------------------------
    always_comb begin
        hit       = 1'b0;
        rd_data   = '0;
        ctrl_we   = 1'b0;
        mask_we   = 1'b0;
        thresh_we = 1'b0;
        w1c       = '0;
        flush     = '0;
        pop       = '0;
        case (word_addr)
            WA_CTRL: begin
                hit     = 1'b1;
                rd_data = DW'(ctrl_q);
                ctrl_we = wr_en;
            end
            WA_STATUS: begin
                hit     = 1'b1;
                rd_data = DW'(status_q);
                if (wr_en) w1c = req_wdata[NCH-1:0];
            end
            WA_MASK: begin
                hit     = 1'b1;
                rd_data = DW'(mask_q);
                mask_we = wr_en;
            end
            WA_THRESH: begin
                hit       = 1'b1;
                rd_data   = DW'(thresh_q);
                thresh_we = wr_en;
            end
            WA_FLUSH: begin
                hit = 1'b1;
                if (wr_en) flush = req_wdata[NCH-1:0];
            end
            default: ;
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (word_addr == WA_COUNT + 10'(c)) begin
                hit     = 1'b1;
                rd_data = DW'(count_q[c]);
            end
            if (word_addr == WA_DATA + 10'(c)) begin
                hit = 1'b1;
                // Empty buffer: data stays 0 and nothing pops.
                if (rd_en && (count_q[c] != '0)) begin
                    rd_data = mem_q[c][rptr_q[c]];
                    pop[c]  = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer pointers, counts and threshold detection
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        set_flag = '0;
        for (int c = 0; c < NCH; c++) begin
            if (flush[c]) begin
                // Flush beats a same-cycle push or pop; the sample is dropped.
                wptr_d[c]  = '0;
                rptr_d[c]  = '0;
                count_d[c] = '0;
            end else begin
                if (push[c]) wptr_d[c] = wptr_q[c] + AW'(1);
                if (pop[c])  rptr_d[c] = rptr_q[c] + AW'(1);
                if (push[c] && !pop[c]) begin
                    count_d[c] = count_q[c] + CW'(1);
                    // THRESH=0 or >DEPTH can never equal count+1 here.
                    set_flag[c] = ((count_q[c] + CW'(1)) == thresh_q);
                end else if (!push[c] && pop[c]) begin
                    count_d[c] = count_q[c] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        ctrl_d   = ctrl_we   ? req_wdata[NCH-1:0] : ctrl_q;
        mask_d   = mask_we   ? req_wdata[NCH-1:0] : mask_q;
        thresh_d = thresh_we ? req_wdata[CW-1:0]  : thresh_q;
        // A set in the same cycle as a W1C of that bit wins.
        status_d = (status_q & ~w1c) | set_flag;
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = req_write ? '0 : rd_data;
                    rsp_err_d   = !hit;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready        = (state_q == S_IDLE);
    assign rsp_valid        = (state_q == S_RESP);
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_err          = rsp_err_q;
    assign sensor_interrupt = |(status_q & mask_q);
    assign bus_state_o      = state_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            status_q    <= '0;
            mask_q      <= '0;
            thresh_q    <= FULL;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            status_q    <= status_d;
            mask_q      <= mask_d;
            thresh_q    <= thresh_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer RAM carries no reset; contents before the first push are unused.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c] && !flush[c]) begin
                mem_q[c][wptr_q[c]] <= sensor_out[c*DW +: DW];
            end
        end
    end

endmodule

// File: doc/sensor_hub.md
# sensor_hub

Multi-channel successor to the single-sensor controller: it samples NCH independent sensors into per-channel buffers of DEPTH words each. Software drains those buffers through a single-beat register-bus slave port, which is bridged from the AXI slave by the top-level wrapper. A threshold-based, maskable, sticky interrupt per channel is ORed onto one interrupt line to the CPU.

## Interface
- NCH, 4: number of sensor channels (1..8).
- DEPTH, 64: words per channel buffer; must be a power of two, ≥2.
- DW, 32: sensor and bus data width.
- CW, $clog2(DEPTH)+1: fill-count width (derived; do not override).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  bus request valid.
- req_ready  out  1  bus request ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  12  byte address, word-aligned (bits [1:0] ignored).
- req_wdata  in  DW  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DW  read data; 0 for writes.
- rsp_err  out  1  1 = unmapped address.
- sensor_ready  in  NCH  per-channel sample valid.
- sensor_out  in  NCH*DW  channel c occupies bits [c*DW +: DW].
- sensor_en  out  NCH  per-channel sample request.
- sensor_interrupt  out  1  OR of (status & mask).

## Operation
- Register map. Accesses to any other address set rsp_err=1; reads return 0 and writes have no effect.
  - 0x000 CTRL, RW, NCH bits: channel enable.
  - 0x004 STATUS, R / W1C: sticky threshold flags.
  - 0x008 MASK, RW: interrupt mask.
  - 0x00C THRESH, RW, CW bits, reset value DEPTH.
  - 0x010 FLUSH, WO: write 1 to bit c to empty buffer c; reads as 0.
  - 0x100+4c COUNT[c], RO: fill count.
  - 0x200+4c DATA[c], RO, popping: returns the head word and pops it. When the buffer is empty, returns 0 and does not pop.
- Buffers: per-channel circular buffer with write pointer, read pointer and count. Pointers are log2(DEPTH) bits and wrap naturally.
- sensor_en[c] = CTRL[c] & (count[c] != DEPTH). This is combinational from registers.
- Push: when sensor_en[c] & sensor_ready[c], sensor_out slice c is written at the write pointer and count increments.
- Push and pop on the same channel in the same cycle: both occur, count is unchanged. A push into a full buffer is impossible because sensor_en is low.
- FLUSH[c] has priority over any push or pop on that channel in the same cycle: pointers and count go to 0 and the sample is dropped.
- STATUS[c] sets on the cycle a push takes count[c] from THRESH-1 to THRESH.
  - THRESH=0 never sets status.
  - THRESH>DEPTH never sets status.
  - If a set and a W1C of the same bit occur in the same cycle, the set wins.
- Clearing CTRL[c] stops sampling only. Buffer contents and count are retained.
- Bus FSM:
  - IDLE: req_ready=1. On req_valid, the request is accepted, the write or pop takes effect in that cycle, rsp_rdata and rsp_err are registered, and the FSM goes to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are held until rsp_ready; on rsp_ready the FSM returns to IDLE.
- Reset values:
  - All outputs 0, except req_ready=1 once out of reset (FSM in IDLE).
  - CTRL, STATUS, MASK = 0; THRESH = DEPTH.
  - All counts and pointers = 0.
  - Buffer RAM contents are don't-care.
- Reset asserted mid-transaction aborts it; any response in flight is lost.

## Timing
- Request-to-response latency is 1 cycle: rsp_valid rises on the cycle after the accepting edge. Maximum throughput is one request per 2 cycles.
- A pushed sample is visible in COUNT and DATA reads accepted from the next cycle onward.
- After the push that fills a buffer, sensor_en[c] deasserts in the following cycle. No sample is accepted at count=DEPTH.
- A pop from a full buffer re-asserts sensor_en[c] in the next cycle.
- sensor_interrupt rises 1 cycle after the threshold-crossing push edge. It falls 1 cycle after the W1C write edge, or after the MASK write edge that masks the bit.
- Posedge ordering within a cycle: pointer and count updates use the pre-edge values of push, pop and flush. There is no read-during-write forwarding beyond the count rule above.

## Test plan
- Reset, then read 0x00C → 64; read 0x004 → 0; sensor_en = 0; sensor_interrupt = 0.
- CTRL=0x1, THRESH=4, MASK=0x1, then drive ch0 samples 0xA0..0xA3 → STATUS=0x1 and interrupt high 1 cycle after the 4th push. Reading DATA[0] four times → 0xA0, 0xA1, 0xA2, 0xA3. A 5th read → 0 with no pop. W1C 0x1 → interrupt low.
- Hold ch2 sensor_ready high for 70 cycles with CTRL=0x4 → COUNT[2]=64 and sensor_en[2]=0. One DATA[2] pop → sensor_en[2]=1 next cycle, then count returns to 64.
- With count[1]=10, issue a DATA[1] pop in the same cycle as a ch1 push → COUNT[1]=10, and the returned word is the oldest sample.
- FLUSH=0x8 written while ch3 has count 5 and sensor_ready is high → COUNT[3]=0 next cycle and that sample is dropped. Reading 0x7F0 → rsp_err=1, rdata=0.
- Hold rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready=0. Assert rst low mid-RESP → rsp_valid=0, all counts 0.
